// File: rtl/bemf_sequencer.sv
// rtl/bemf_sequencer.sv - back-EMF sampling sequencer and per-motor register files
//
// Purpose: on each PWM off-window trigger, walks the masked motors in ascending
// order, runs a high-side then low-side ADC conversion per motor, issues one
// beat to the downstream update pipeline and writes the returned accumulator
// back into the per-motor register file.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   enable, sample_trig, mot_mask   sequencing control
//   adc_start, adc_chan             conversion request (chan 2m = high, 2m+1 = low)
//   adc_done, adc_data              conversion result
//   bemf_adc_h/l, mot_sel_in,
//   in_valid, bemf_in,
//   bemf_calib_in                   beat to the update pipeline
//   bemf_out, mot_sel_out,
//   out_valid                       writeback from the update pipeline
//   cal_we, cal_sel, cal_data       calibration register write
//   clr                             per-motor accumulator clear
//   rd_sel, rd_data                 registered accumulator readback
//   busy, overrun, wb_err, err_clr  status and sticky error flags
module bemf_sequencer #(
    parameter int SETTLE_CYCLES = 16,
    parameter int WB_TIMEOUT    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        sample_trig,
    input  logic [3:0]  mot_mask,
    output logic        adc_start,
    output logic [2:0]  adc_chan,
    input  logic        adc_done,
    input  logic [9:0]  adc_data,
    output logic [9:0]  bemf_adc_h,
    output logic [9:0]  bemf_adc_l,
    output logic [1:0]  mot_sel_in,
    output logic        in_valid,
    output logic [35:0] bemf_in,
    output logic [35:0] bemf_calib_in,
    input  logic [35:0] bemf_out,
    input  logic [1:0]  mot_sel_out,
    input  logic        out_valid,
    input  logic        cal_we,
    input  logic [1:0]  cal_sel,
    input  logic [35:0] cal_data,
    input  logic [3:0]  clr,
    input  logic [1:0]  rd_sel,
    output logic [35:0] rd_data,
    output logic        busy,
    output logic        overrun,
    output logic        wb_err,
    input  logic        err_clr
);

    typedef enum logic [2:0] {IDLE, SETTLE, CONV_H, CONV_L, ISSUE, WAIT_WB} state_t;

    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] WB_LOAD     = 16'(WB_TIMEOUT);

    state_t      state, state_d;
    logic [15:0] cnt, cnt_d;
    logic [1:0]  idx, idx_d;
    logic [3:0]  mask_q, mask_d;
    logic        start_d, valid_d;
    logic [2:0]  chan_d;
    logic        wb_write, wb_bad;
    logic [1:0]  first_idx, next_idx;
    logic        has_next;

    logic [35:0] acc [4];
    logic [35:0] cal [4];
    logic [9:0]  adc_h_q;
    logic [35:0] beat_acc, beat_cal;

    assign busy = (state != IDLE);

    // Register-file values are presented live on the beat cycle and frozen
    // afterwards so the beat outputs stay stable between beats.
    assign bemf_in       = in_valid ? acc[idx] : beat_acc;
    assign bemf_calib_in = in_valid ? cal[idx] : beat_cal;

    // Lowest set bit of the incoming mask, and lowest set bit of the captured
    // mask strictly above the current motor.
    always_comb begin
        first_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mot_mask[i]) first_idx = 2'(i);
        end
        has_next = 1'b0;
        next_idx = idx;
        for (int i = 3; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(idx))) begin
                has_next = 1'b1;
                next_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        idx_d    = idx;
        mask_d   = mask_q;
        start_d  = 1'b0;
        chan_d   = adc_chan;
        valid_d  = 1'b0;
        wb_write = 1'b0;
        wb_bad   = 1'b0;
        case (state)
            IDLE: begin
                if (enable && sample_trig && (mot_mask != 4'd0)) begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_LOAD;
                    idx_d   = first_idx;
                    mask_d  = mot_mask;
                end
            end
            SETTLE: begin
                if (cnt == 16'd0) begin
                    state_d = CONV_H;
                    start_d = 1'b1;
                    chan_d  = {idx, 1'b0};
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
            CONV_H: begin
                if (adc_done) begin
                    state_d = CONV_L;
                    start_d = 1'b1;
                    chan_d  = {idx, 1'b1};
                end
            end
            CONV_L: begin
                if (adc_done) begin
                    state_d = ISSUE;
                    valid_d = 1'b1;
                    // Counting starts on the beat cycle so wb_err rises
                    // exactly WB_TIMEOUT cycles after the beat.
                    cnt_d   = WB_LOAD;
                end
            end
            ISSUE: begin
                state_d = WAIT_WB;
                cnt_d   = (cnt != 16'd0) ? cnt - 16'd1 : cnt;
            end
            WAIT_WB: begin
                cnt_d = (cnt != 16'd0) ? cnt - 16'd1 : cnt;
                if (out_valid && (mot_sel_out == idx)) begin
                    wb_write = 1'b1;
                end else begin
                    if (out_valid) wb_bad = 1'b1;
                    if (cnt <= 16'd1) wb_bad = 1'b1;
                end
                if (wb_write || (cnt <= 16'd1)) begin
                    if (has_next && enable) begin
                        state_d = SETTLE;
                        cnt_d   = SETTLE_LOAD;
                        idx_d   = next_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            mask_q     <= '0;
            adc_start  <= 1'b0;
            adc_chan   <= '0;
            in_valid   <= 1'b0;
            adc_h_q    <= '0;
            bemf_adc_h <= '0;
            bemf_adc_l <= '0;
            mot_sel_in <= '0;
            beat_acc   <= '0;
            beat_cal   <= '0;
            rd_data    <= '0;
            overrun    <= 1'b0;
            wb_err     <= 1'b0;
            for (int m = 0; m < 4; m++) begin
                acc[m] <= '0;
                cal[m] <= '0;
            end
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            idx       <= idx_d;
            mask_q    <= mask_d;
            adc_start <= start_d;
            adc_chan  <= chan_d;
            in_valid  <= valid_d;

            if (state == CONV_H && adc_done) adc_h_q <= adc_data;
            if (state == CONV_L && adc_done) begin
                bemf_adc_h <= adc_h_q;
                bemf_adc_l <= adc_data;
                mot_sel_in <= idx;
            end
            if (in_valid) begin
                beat_acc <= acc[idx];
                beat_cal <= cal[idx];
            end

            for (int m = 0; m < 4; m++) begin
                if (clr[m]) acc[m] <= '0;
                else if (wb_write && (idx == 2'(m))) acc[m] <= bemf_out;
            end
            if (cal_we) cal[cal_sel] <= cal_data;

            rd_data <= acc[rd_sel];

            if (sample_trig && busy) overrun <= 1'b1;
            else if (err_clr)        overrun <= 1'b0;

            if (wb_bad)       wb_err <= 1'b1;
            else if (err_clr) wb_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bemf_sequencer.sv
// tb/tb_bemf_sequencer.sv - directed bench for bemf_sequencer with ADC and update-pipeline models
module tb_bemf_sequencer;

    logic        clk, reset, enable, sample_trig;
    logic [3:0]  mot_mask;
    logic        adc_start;
    logic [2:0]  adc_chan;
    logic        adc_done;
    logic [9:0]  adc_data;
    logic [9:0]  bemf_adc_h, bemf_adc_l;
    logic [1:0]  mot_sel_in;
    logic        in_valid;
    logic [35:0] bemf_in, bemf_calib_in, bemf_out;
    logic [1:0]  mot_sel_out;
    logic        out_valid;
    logic        cal_we;
    logic [1:0]  cal_sel;
    logic [35:0] cal_data;
    logic [3:0]  clr;
    logic [1:0]  rd_sel;
    logic [35:0] rd_data;
    logic        busy, overrun, wb_err, err_clr;

    localparam logic [35:0] NEG10 = 36'hFFFFFFFF6;

    bemf_sequencer #(.SETTLE_CYCLES(4), .WB_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sample_trig(sample_trig),
        .mot_mask(mot_mask), .adc_start(adc_start), .adc_chan(adc_chan),
        .adc_done(adc_done), .adc_data(adc_data), .bemf_adc_h(bemf_adc_h),
        .bemf_adc_l(bemf_adc_l), .mot_sel_in(mot_sel_in), .in_valid(in_valid),
        .bemf_in(bemf_in), .bemf_calib_in(bemf_calib_in), .bemf_out(bemf_out),
        .mot_sel_out(mot_sel_out), .out_valid(out_valid), .cal_we(cal_we),
        .cal_sel(cal_sel), .cal_data(cal_data), .clr(clr), .rd_sel(rd_sel),
        .rd_data(rd_data), .busy(busy), .overrun(overrun), .wb_err(wb_err),
        .err_clr(err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          due;
        logic [1:0]  sel;
        logic [35:0] val;
    } wb_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          adc_cnt = 0;
    logic [2:0]  pend_chan;
    wb_t         wb_q[$];
    logic [2:0]  chan_log[$];
    logic [1:0]  sel_log[$];
    logic [35:0] cal_log[$];
    int          beat_cyc[$];
    int          drop_mot    = -1;
    bit          ovr_en      = 1'b0;
    logic [35:0] ovr_val     = '0;
    bit          clr_on_wb   = 1'b0;
    bit          cal_on_iss  = 1'b0;
    logic [35:0] cal_iss_val = '0;
    int          err_cyc     = -1;
    int          n_start     = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: advance, then run the ADC (3-cycle) and update-pipeline
    // (4-cycle, acc + h - l) models off the active edge.
    task automatic step();
        wb_t e;
        @(posedge clk);
        #1;
        cyc++;
        adc_done  = 1'b0;
        out_valid = 1'b0;
        clr       = 4'd0;
        cal_we    = 1'b0;
        err_clr   = 1'b0;
        if (adc_cnt > 0) begin
            adc_cnt--;
            if (adc_cnt == 0) begin
                adc_done = 1'b1;
                adc_data = 10'(int'(pend_chan) * 10);
            end
        end
        if (adc_start) begin
            adc_cnt   = 3;
            pend_chan = adc_chan;
            chan_log.push_back(adc_chan);
            n_start++;
        end
        if (wb_q.size() > 0 && wb_q[0].due == cyc) begin
            e = wb_q.pop_front();
            if (int'(e.sel) != drop_mot) begin
                out_valid   = 1'b1;
                mot_sel_out = e.sel;
                bemf_out    = ovr_en ? ovr_val : e.val;
                if (clr_on_wb && e.sel == 2'd0) clr = 4'b0001;
            end
        end
        if (in_valid) begin
            sel_log.push_back(mot_sel_in);
            cal_log.push_back(bemf_calib_in);
            beat_cyc.push_back(cyc);
            e.due = cyc + 4;
            e.sel = mot_sel_in;
            e.val = bemf_in + {26'd0, bemf_adc_h} - {26'd0, bemf_adc_l};
            wb_q.push_back(e);
            if (cal_on_iss && mot_sel_in == 2'd2) begin
                cal_we   = 1'b1;
                cal_sel  = 2'd2;
                cal_data = cal_iss_val;
            end
        end
        if (wb_err && err_cyc < 0) err_cyc = cyc;
    endtask

    task automatic clear_logs();
        chan_log.delete();
        sel_log.delete();
        cal_log.delete();
        beat_cyc.delete();
    endtask

    task automatic trigger(input logic [3:0] m);
        mot_mask    = m;
        enable      = 1'b1;
        sample_trig = 1'b1;
        step();
        sample_trig = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 500) begin
            step();
            n++;
        end
        check_eq({tag, " idle"}, 64'(busy), 64'd0);
    endtask

    task automatic sweep(input string tag, input logic [3:0] m);
        clear_logs();
        trigger(m);
        wait_idle(tag);
    endtask

    task automatic check_acc(input string tag, input int m, input logic [35:0] exp);
        rd_sel = 2'(m);
        step();
        check_eq(tag, 64'(rd_data), 64'(exp));
    endtask

    task automatic check_chans(input string tag, input int n, input int exp[8]);
        check_eq({tag, " nchan"}, 64'(chan_log.size()), 64'(n));
        for (int i = 0; i < n; i++)
            check_eq({tag, " chan"}, (i < chan_log.size()) ? 64'(chan_log[i]) : 64'hDEAD, 64'(exp[i]));
    endtask

    task automatic check_beats(input string tag, input int n, input int sel[4], input logic [35:0] calv[4]);
        check_eq({tag, " nbeat"}, 64'(sel_log.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            check_eq({tag, " sel"}, (i < sel_log.size()) ? 64'(sel_log[i]) : 64'hDEAD, 64'(sel[i]));
            check_eq({tag, " cal"}, (i < cal_log.size()) ? 64'(cal_log[i]) : 64'hDEAD, 64'(calv[i]));
        end
    endtask

    task automatic clear_all_acc();
        clr = 4'b1111;
        step();
    endtask

    initial begin
        int n;
        reset = 1'b1; enable = 1'b0; sample_trig = 1'b0; mot_mask = '0;
        adc_done = 1'b0; adc_data = '0; bemf_out = '0; mot_sel_out = '0;
        out_valid = 1'b0; cal_we = 1'b0; cal_sel = '0; cal_data = '0;
        clr = '0; rd_sel = '0; err_clr = 1'b0;
        repeat (3) step();
        check_eq("rst adc_start", 64'(adc_start), 64'd0);
        check_eq("rst adc_chan", 64'(adc_chan), 64'd0);
        check_eq("rst in_valid", 64'(in_valid), 64'd0);
        check_eq("rst busy", 64'(busy), 64'd0);
        check_eq("rst flags", 64'({overrun, wb_err}), 64'd0);
        check_eq("rst rd_data", 64'(rd_data), 64'd0);
        reset = 1'b0;
        step();

        // Full sweep
        sweep("full", 4'b1111);
        check_chans("full", 8, '{0, 1, 2, 3, 4, 5, 6, 7});
        check_beats("full", 4, '{0, 1, 2, 3}, '{36'd0, 36'd0, 36'd0, 36'd0});
        for (int m = 0; m < 4; m++) check_acc("full acc", m, NEG10);
        check_eq("full wb_err", 64'(wb_err), 64'd0);

        // Masked sweep
        clear_all_acc();
        sweep("mask", 4'b1010);
        check_chans("mask", 4, '{2, 3, 6, 7, 0, 0, 0, 0});
        check_beats("mask", 2, '{1, 3, 0, 0}, '{36'd0, 36'd0, 36'd0, 36'd0});
        check_acc("mask acc0", 0, 36'd0);
        check_acc("mask acc1", 1, NEG10);
        check_acc("mask acc2", 2, 36'd0);
        check_acc("mask acc3", 3, NEG10);

        // Calibration forwarding, including a write on the ISSUE cycle
        cal_we = 1'b1; cal_sel = 2'd2; cal_data = 36'd25;
        step();
        sweep("cal", 4'b1111);
        check_beats("cal", 4, '{0, 1, 2, 3}, '{36'd0, 36'd0, 36'd25, 36'd0});
        cal_on_iss = 1'b1; cal_iss_val = 36'd77;
        sweep("cal iss", 4'b1111);
        cal_on_iss = 1'b0;
        check_beats("cal iss", 4, '{0, 1, 2, 3}, '{36'd0, 36'd0, 36'd25, 36'd0});
        sweep("cal new", 4'b1111);
        check_beats("cal new", 4, '{0, 1, 2, 3}, '{36'd0, 36'd0, 36'd77, 36'd0});

        // Overrun and writeback timeout
        clear_all_acc();
        drop_mot = 1;
        err_cyc  = -1;
        clear_logs();
        trigger(4'b1111);
        n = 0;
        while (!adc_start && n < 100) begin step(); n++; end
        check_eq("ovr reach convh", 64'(adc_start), 64'd1);
        sample_trig = 1'b1;
        step();
        sample_trig = 1'b0;
        check_eq("ovr flag", 64'(overrun), 64'd1);
        wait_idle("ovr");
        drop_mot = -1;
        check_eq("to wb_err", 64'(wb_err), 64'd1);
        check_eq("to latency", (beat_cyc.size() > 1) ? 64'(err_cyc - beat_cyc[1]) : 64'hDEAD, 64'd8);
        check_chans("ovr", 8, '{0, 1, 2, 3, 4, 5, 6, 7});
        check_acc("to acc1", 1, 36'd0);
        check_acc("to acc2", 2, NEG10);
        err_clr = 1'b1;
        step();
        check_eq("errclr flags", 64'({overrun, wb_err}), 64'd0);

        // Clear racing a writeback, then the same writeback with no clear
        clear_all_acc();
        ovr_en = 1'b1; ovr_val = 36'd500; clr_on_wb = 1'b1;
        sweep("race", 4'b0001);
        clr_on_wb = 1'b0;
        check_acc("race acc0", 0, 36'd0);
        sweep("norace", 4'b0001);
        ovr_en = 1'b0;
        check_acc("norace acc0", 0, 36'd500);

        // Reset during CONV_L of motor 1
        cal_we = 1'b1; cal_sel = 2'd1; cal_data = 36'd9;
        step();
        clear_logs();
        trigger(4'b0010);
        n = 0;
        while (!(adc_start && adc_chan == 3'd3) && n < 100) begin step(); n++; end
        check_eq("rst reach convl", 64'(adc_start && adc_chan == 3'd3), 64'd1);
        step();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        wb_q.delete();
        clear_logs();
        n_start = 0;
        repeat (3) step();
        adc_done = 1'b1; adc_data = 10'd5;
        step();
        out_valid = 1'b1; mot_sel_out = 2'd1; bemf_out = 36'd123;
        step();
        repeat (8) step();
        check_eq("rst2 adc_start", 64'(adc_start), 64'd0);
        check_eq("rst2 nstart", 64'(n_start), 64'd0);
        check_eq("rst2 busy", 64'(busy), 64'd0);
        check_eq("rst2 nbeat", 64'(sel_log.size()), 64'd0);
        for (int m = 0; m < 4; m++) check_acc("rst2 acc", m, 36'd0);
        sweep("restart", 4'b1111);
        check_chans("restart", 8, '{0, 1, 2, 3, 4, 5, 6, 7});
        check_beats("restart", 4, '{0, 1, 2, 3}, '{36'd0, 36'd0, 36'd0, 36'd0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
